// File: rtl/pipe_field.sv
// Scrolling pipe field for the Flappy Bird game: spawns gapped pipes, detects collisions, keeps score.
// Optional macro PIPE_FIELD_SPEEDUP_EN adds a scroll divider whose period shrinks as the score rises.
//
// state  | meaning
// IDLE   | waiting for key, field empty
// RUN    | pipes scroll on tick, collision checked every clk
// OVER   | everything frozen until a key rising edge
module pipe_field #(
  parameter int          COLS    = 8,
  parameter int          GAP     = 3,
  parameter int          SPACING = 4,
  parameter logic [15:0] SEED    = 16'hACE1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tick,
  input  logic                 key,
  input  logic [15:0]          bird_lights,
  output logic [COLS*16-1:0]   pipes,
  output logic [7:0]           score,
  output logic                 running,
  output logic                 game_over
);

  localparam logic [1:0]  S_IDLE     = 2'd0;
  localparam logic [1:0]  S_RUN      = 2'd1;
  localparam logic [1:0]  S_OVER     = 2'd2;
  localparam logic [3:0]  SPAWN_LAST = 4'(SPACING + 1);
  localparam logic [3:0]  GAP_MAX    = 4'(16 - GAP);
  localparam logic [15:0] GAP_ONES   = 16'((1 << GAP) - 1);

  logic [1:0]  state, state_next;
  logic [15:0] lfsr;
  logic        lfsr_fb;
  logic        key_q;
  logic [3:0]  spawn_cnt, gap_lo, gap_pick, gap_use;
  logic [15:0] col0, col1, wall_mask, new_col;
  logic        hit, scroll, scroll_ok, cleared, run_entry;

  assign col0      = pipes[15:0];
  assign col1      = pipes[31:16];
  assign hit       = (state == S_RUN) && ((|(bird_lights & col0)) || (bird_lights == 16'h0001));
  assign cleared   = (col0 != 16'h0000) && (col1 == 16'h0000);
  assign run_entry = (state == S_IDLE) && key;
  assign scroll    = (state == S_RUN) && tick && !hit && scroll_ok;
  assign lfsr_fb   = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];

  // Fold the random nibble back so the whole gap fits inside the 16 rows.
  assign gap_pick  = (lfsr[3:0] > GAP_MAX) ? (lfsr[3:0] - GAP_MAX) : lfsr[3:0];
  assign gap_use   = (spawn_cnt == 4'd0) ? gap_pick : gap_lo;
  assign wall_mask = ~(GAP_ONES << gap_use);
  assign new_col   = (spawn_cnt <= 4'd1) ? wall_mask : 16'h0000;

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (key) state_next = S_RUN;
      S_RUN:   if (hit) state_next = S_OVER;
      S_OVER:  if (key && !key_q) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      running   <= 1'b0;
      game_over <= 1'b0;
      lfsr      <= SEED;
      key_q     <= 1'b0;
      pipes     <= '0;
      score     <= 8'd0;
      spawn_cnt <= 4'd0;
      gap_lo    <= 4'd0;
    end else begin
      state     <= state_next;
      running   <= (state_next == S_RUN);
      game_over <= (state_next == S_OVER);
      lfsr      <= {lfsr_fb, lfsr[15:1]};
      key_q     <= key;
      if (run_entry) begin
        score     <= 8'd0;
        spawn_cnt <= 4'd0;
      end
      if ((state == S_OVER) && (state_next == S_IDLE))
        pipes <= '0;
      if (scroll) begin
        pipes     <= {new_col, pipes[COLS*16-1:16]};
        spawn_cnt <= (spawn_cnt == SPAWN_LAST) ? 4'd0 : spawn_cnt + 4'd1;
        if (spawn_cnt == 4'd0)
          gap_lo <= gap_pick;
        if (cleared && (score != 8'hFF))
          score <= score + 8'd1;
      end
    end
  end

`ifdef PIPE_FIELD_SPEEDUP_EN
  logic [2:0] period, period_next, div_cnt;

  // Period drops when this scroll's score increment lands on a multiple of 8.
  assign period_next = (cleared && (score != 8'hFF) && (score[2:0] == 3'd7) && (period > 3'd1))
                       ? period - 3'd1 : period;
  assign scroll_ok   = (div_cnt == 3'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      period  <= 3'd4;
      div_cnt <= 3'd0;
    end else if (run_entry) begin
      period  <= 3'd4;
      div_cnt <= 3'd0;
    end else if ((state == S_RUN) && tick && !hit) begin
      if (div_cnt != 3'd0) begin
        div_cnt <= div_cnt - 3'd1;
      end else begin
        period  <= period_next;
        div_cnt <= period_next - 3'd1;
      end
    end
  end
`else
  assign scroll_ok = 1'b1;
`endif

endmodule

// File: tb/tb_pipe_field.sv
// Self-checking bench for pipe_field: directed scenarios plus randomized play against a behavioural model.
module tb_pipe_field;
  localparam int          COLS    = 8;
  localparam int          GAP     = 3;
  localparam int          SPACING = 4;
  localparam logic [15:0] SEED    = 16'hACE1;

  logic                clk = 1'b0;
  logic                reset, tick, key;
  logic [15:0]         bird_lights;
  logic [COLS*16-1:0]  pipes;
  logic [7:0]          score;
  logic                running, game_over;

  always #5 clk = ~clk;

  pipe_field #(.COLS(COLS), .GAP(GAP), .SPACING(SPACING), .SEED(SEED)) dut (
    .clk(clk), .reset(reset), .tick(tick), .key(key), .bird_lights(bird_lights),
    .pipes(pipes), .score(score), .running(running), .game_over(game_over)
  );

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Behavioural model: game state 0=idle 1=run 2=over, field as an array of columns.
  int          m_state  = 0;
  logic [15:0] m_col[COLS];
  int          m_score  = 0;
  int          m_spawn  = 0;
  int          m_gap    = 0;
  logic [15:0] m_lfsr   = SEED;
  bit          m_key_q  = 1'b0;
  int          m_period = 4;
  int          m_div    = 0;

  function automatic logic [15:0] gap_mask(input int g);
    logic [15:0] m;
    for (int r = 0; r < 16; r++) m[r] = !((r >= g) && (r < g + GAP));
    return m;
  endfunction

  function automatic logic [255:0] m_pipes();
    logic [255:0] r = '0;
    for (int c = 0; c < COLS; c++) r[c*16 +: 16] = m_col[c];
    return r;
  endfunction

  task automatic m_scroll();
    int v;
    logic [15:0] nc;
    bit passed;
    passed = (m_col[0] != 0) && (m_col[1] == 0);
    if (m_spawn == 0) begin
      v = int'(m_lfsr[3:0]);
      if (v > 16 - GAP) v = v - (16 - GAP);
      m_gap = v;
      nc = gap_mask(v);
    end else if (m_spawn == 1) begin
      nc = gap_mask(m_gap);
    end else begin
      nc = 16'h0000;
    end
    for (int c = 0; c < COLS - 1; c++) m_col[c] = m_col[c+1];
    m_col[COLS-1] = nc;
    m_spawn = (m_spawn + 1) % (2 + SPACING);
    if (passed && m_score < 255) begin
      m_score++;
      if ((m_score % 8 == 0) && (m_period > 1)) m_period--;
    end
    m_div = m_period - 1;
  endtask

  always @(posedge clk) begin
    if (reset) begin
      m_state = 0;
      for (int c = 0; c < COLS; c++) m_col[c] = 16'h0000;
      m_score = 0; m_spawn = 0; m_gap = 0;
      m_lfsr = SEED; m_key_q = 1'b0; m_period = 4; m_div = 0;
    end else begin
      case (m_state)
        0: if (key) begin
             m_state = 1; m_score = 0; m_spawn = 0; m_period = 4; m_div = 0;
           end
        1: begin
             if (((bird_lights & m_col[0]) != 0) || (bird_lights == 16'h0001)) m_state = 2;
             else if (tick) begin
`ifdef PIPE_FIELD_SPEEDUP_EN
               if (m_div != 0) m_div--;
               else m_scroll();
`else
               m_scroll();
`endif
             end
           end
        default: if (key && !m_key_q) begin
             m_state = 0;
             for (int c = 0; c < COLS; c++) m_col[c] = 16'h0000;
           end
      endcase
      m_lfsr  = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
      m_key_q = key;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("pipes", 256'(pipes), m_pipes());
      chk("score", 256'(score), 256'(m_score));
      chk("running", 256'(running), 256'(m_state == 1));
      chk("game_over", 256'(game_over), 256'(m_state == 2));
    end
  end

  // Bird stays in the gap of whichever pipe is nearest the bird column.
  function automatic logic [15:0] follow(input logic [15:0] cur);
    logic [15:0] c;
    c = (m_col[0] != 0) ? m_col[0] : m_col[1];
    if (c == 0) return (cur == 16'h0001) ? 16'h0080 : cur;
    for (int r = 15; r >= 0; r--) if (!c[r]) return 16'(1) << r;
    return cur;
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int n;
    bit done;
    logic [255:0] exp_pipes;
    int exp_score;
    reset = 1'b1; tick = 1'b0; key = 1'b0; bird_lights = 16'h0080;
    @(negedge clk);
    cmp_en = 1'b1;
    step();
    chk("rst_pipes", 256'(pipes), '0);
    chk("rst_score", 256'(score), '0);
    chk("rst_running", 256'(running), '0);
    chk("rst_game_over", 256'(game_over), '0);

    reset = 1'b0; key = 1'b1;
    step();
    key = 1'b0;
    chk("key_running", 256'(running), 256'(1));

    n = 0;
    while (m_lfsr[3:0] != 4'd5 && n < 2000) begin step(); n++; end
    chk("lfsr5_found", 256'(n < 2000), 256'(1));
    tick = 1'b1;
    step();
    chk("spawn5_col_last", 256'(pipes[(COLS-1)*16 +: 16]), 256'(16'hFF1F));
    step();
    chk("spawn5_col_prev", 256'(pipes[(COLS-2)*16 +: 16]), 256'(16'hFF1F));
    chk("spawn5_col_last2", 256'(pipes[(COLS-1)*16 +: 16]), 256'(16'hFF1F));
    step();
    chk("spawn5_col_empty", 256'(pipes[(COLS-1)*16 +: 16]), 256'(0));
    for (int k = 4; k <= 9; k++) begin
      bird_lights = follow(bird_lights);
      step();
    end
    chk("score_before_clear", 256'(score), 256'(0));
    bird_lights = follow(bird_lights);
    step();
    chk("score_after_clear", 256'(score), 256'(1));

    n = 0; done = 1'b0;
    while (!done && n < 3000) begin
      bird_lights = follow(bird_lights);
      if (m_spawn == 0) begin
        tick = (m_lfsr[3:0] == 4'hF);
        done = tick;
      end else tick = 1'b1;
      step();
      n++;
    end
    tick = 1'b0;
    chk("lfsr15_found", 256'(done), 256'(1));
    chk("spawn15_col_last", 256'(pipes[(COLS-1)*16 +: 16]), 256'(16'hFFE3));

    n = 0; tick = 1'b1;
    while (m_col[0] == 0 && n < 200) begin
      bird_lights = follow(bird_lights);
      step();
      n++;
    end
    chk("wall_in_col0", 256'(m_col[0] != 0), 256'(1));
    for (int r = 0; r < 16; r++) if (m_col[0][r]) bird_lights = 16'(1) << r;
    exp_pipes = m_pipes(); exp_score = m_score;
    step();
    tick = 1'b0;
    chk("hit_game_over", 256'(game_over), 256'(1));
    chk("hit_pipes_frozen", 256'(pipes), exp_pipes);
    chk("hit_score_frozen", 256'(score), 256'(exp_score));

    key = 1'b1; step(); key = 1'b0;
    chk("over_to_idle_pipes", 256'(pipes), '0);
    chk("idle_score_kept", 256'(score), 256'(exp_score));
    chk("idle_game_over", 256'(game_over), 256'(0));
    step();
    bird_lights = 16'h0080;
    key = 1'b1; step(); key = 1'b0;
    chk("rerun_running", 256'(running), 256'(1));
    chk("rerun_score_clear", 256'(score), 256'(0));
    bird_lights = 16'h0001;
    step();
    chk("floor_game_over", 256'(game_over), 256'(1));
    bird_lights = 16'h0080;

    for (int i = 0; i < 5000; i++) begin
      reset = ($urandom_range(0, 999) == 0);
      tick  = ($urandom_range(0, 2) == 0);
      key   = (m_state != 1) ? ($urandom_range(0, 5) == 0) : 1'($urandom_range(0, 1));
      if ($urandom_range(0, 199) == 0) bird_lights = 16'(1) << $urandom_range(0, 15);
      else bird_lights = follow(bird_lights);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
